// File: rtl/pong_game_ctrl_pkg.sv
// Shared definitions for the pong game controller: state encodings,
// BCD digit width and default game timing.
package pong_game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int unsigned BCD_W            = 4;
  localparam int unsigned DEF_BALLS        = 3;
  localparam int unsigned DEF_SERVE_FRAMES = 120;
  localparam int unsigned DEF_OVER_FRAMES  = 180;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Event/status bundle between the pong controller and the graphics datapath.
interface pong_game_ctrl_if;

  logic       tick_60Hz;
  logic       btn_start;
  logic       paddle_hit;
  logic       ball_miss;
  logic       run;
  logic       ball_reload;
  logic [7:0] score;
  logic [1:0] balls_left;
  logic       game_over;
  logic [2:0] state_dbg;

  modport master (
    output tick_60Hz, btn_start, paddle_hit, ball_miss,
    input  run, ball_reload, score, balls_left, game_over, state_dbg
  );

  modport slave (
    input  tick_60Hz, btn_start, paddle_hit, ball_miss,
    output run, ball_reload, score, balls_left, game_over, state_dbg
  );

endinterface

// File: rtl/pong_game_ctrl_bcd2_counter.sv
// Two-digit BCD up-counter with synchronous clear (priority) and 99->00 wrap.
module bcd2_counter
  import pong_game_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [2*BCD_W-1:0] q
);

  logic [BCD_W-1:0] ones_q, ones_d;
  logic [BCD_W-1:0] tens_q, tens_d;

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr) begin
      ones_d = '0;
      tens_d = '0;
    end else if (inc) begin
      if (ones_q == BCD_W'(9)) begin
        ones_d = '0;
        tens_d = (tens_q == BCD_W'(9)) ? '0 : tens_q + BCD_W'(1);
      end else begin
        ones_d = ones_q + BCD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
      tens_q <= '0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign q = {tens_q, ones_q};

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: start edge detect, frame timer and the
// IDLE/SERVE/PLAY/MISS/OVER flow driving run, reloads, score and balls.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter int unsigned BALLS        = DEF_BALLS,
  parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int unsigned OVER_FRAMES  = DEF_OVER_FRAMES
) (
  input  logic           clk,
  input  logic           reset,
  pong_game_ctrl_if.slave gif
);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] balls_q, balls_d;
  logic       reload_q, reload_d;
  logic       run_q;
  logic       over_q;
  logic       btn_q;
  logic       start;
  logic       score_clr;
  logic       score_inc;
  logic [1:0] balls_dec;

  assign start     = gif.btn_start & ~btn_q;
  assign balls_dec = balls_q - 2'd1;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    balls_d   = balls_q;
    reload_d  = 1'b0;
    score_clr = 1'b0;
    score_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SERVE;
          timer_d   = '0;
          balls_d   = 2'(BALLS);
          reload_d  = 1'b1;
          score_clr = 1'b1;
        end
      end
      ST_SERVE, ST_MISS: begin
        if (gif.tick_60Hz) begin
          if (timer_q == 8'(SERVE_FRAMES - 1)) begin
            state_d = ST_PLAY;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
      end
      ST_PLAY: begin
        // A miss in the same clk as a hit swallows the hit.
        if (gif.ball_miss) begin
          balls_d = balls_dec;
          timer_d = '0;
          if (balls_dec == 2'd0) begin
            state_d = ST_OVER;
          end else begin
            state_d  = ST_MISS;
            reload_d = 1'b1;
          end
        end else if (gif.paddle_hit) begin
          score_inc = 1'b1;
        end
      end
      ST_OVER: begin
        if (start) begin
          state_d   = ST_SERVE;
          timer_d   = '0;
          balls_d   = 2'(BALLS);
          reload_d  = 1'b1;
          score_clr = 1'b1;
        end else if (gif.tick_60Hz) begin
          if (timer_q == 8'(OVER_FRAMES - 1)) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      balls_q  <= 2'(BALLS);
      reload_q <= 1'b0;
      run_q    <= 1'b0;
      over_q   <= 1'b0;
      btn_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      balls_q  <= balls_d;
      reload_q <= reload_d;
      run_q    <= (state_d == ST_PLAY);
      over_q   <= (state_d == ST_OVER);
      btn_q    <= gif.btn_start;
    end
  end

  bcd2_counter u_score (
    .clk   (clk),
    .rst_n (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .q     (gif.score)
  );

  assign gif.run         = run_q;
  assign gif.ball_reload = reload_q;
  assign gif.balls_left  = balls_q;
  assign gif.game_over   = over_q;
  assign gif.state_dbg   = state_q;

endmodule
